// File: rtl/db15_joy_tx.sv
// db15_joy_tx: device-side DB15 two-player joystick responder emulating chained 74HC165s.
// Optional link-idle timeout is compiled in with `define DB15_TX_TIMEOUT_EN.
`default_nettype none

module db15_joy_tx #(
  parameter int TIMEOUT_CYCLES = 2_400_000,
  parameter bit FILL_BIT       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_load,
  input  logic        joy_clk,
  output logic        joy_data,
  output logic        link_active,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_load_meta, r_load_sync, r_load_d;
  logic        r_clk_meta, r_clk_sync, r_clk_d;
  logic [31:0] r_frame;
  logic [5:0]  r_cnt;
  logic        r_overrun;
  logic        r_link_active;

  logic        w_load_fall;
  logic        w_clk_rise;
  logic        w_timeout;

  // Load idles high, so its synchronizer resets high to avoid a false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_meta <= 1'b1;
      r_load_sync <= 1'b1;
      r_load_d    <= 1'b1;
      r_clk_meta  <= 1'b0;
      r_clk_sync  <= 1'b0;
      r_clk_d     <= 1'b0;
    end else begin
      r_load_meta <= joy_load;
      r_load_sync <= r_load_meta;
      r_load_d    <= r_load_sync;
      r_clk_meta  <= joy_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_d     <= r_clk_sync;
    end
  end

  assign w_load_fall = ~r_load_sync & r_load_d;
  assign w_clk_rise  = r_clk_sync & ~r_clk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame   <= '1;
      r_cnt     <= 6'd0;
      r_overrun <= 1'b0;
    end else if (!r_load_sync) begin
      r_frame <= {~joystick2, ~joystick1};
      r_cnt   <= 6'd0;
    end else if (w_clk_rise) begin
      r_frame <= {FILL_BIT, r_frame[31:1]};
      if (r_cnt != 6'd63) begin
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_cnt >= 6'd32) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef DB15_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_load_fall || !r_link_active) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Fires on the cycle the idle count reaches TIMEOUT_CYCLES.
  assign w_timeout = r_link_active && !w_load_fall &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_link_active <= 1'b0;
    end else if (w_load_fall) begin
      r_link_active <= 1'b1;
    end else if (w_timeout) begin
      r_link_active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_load_sync) w_state_next = S_LOAD;
      S_LOAD:  if (r_load_sync)  w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (!r_load_sync) begin
          w_state_next = S_LOAD;
        end else if (w_clk_rise && (r_cnt == 6'd31)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  if (!r_load_sync) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end
  end

  assign joy_data    = r_frame[0];
  assign link_active = r_link_active;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_db15_joy_tx.sv
// Self-checking bench for db15_joy_tx: scoreboard of expected serial bits per frame.
`default_nettype none

module tb_db15_joy_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joystick1 = 16'h0000;
  logic [15:0] joystick2 = 16'h0000;
  logic        joy_load = 1'b1;
  logic        joy_clk = 1'b0;
  logic        joy_data;
  logic        link_active;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  bit exp_bit;

  db15_joy_tx #(
    .TIMEOUT_CYCLES(100),
    .FILL_BIT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .joy_load(joy_load),
    .joy_clk(joy_clk),
    .joy_data(joy_data),
    .link_active(link_active),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_load();
    joy_load = 1'b0;
    wait_cyc(4);
    joy_load = 1'b1;
    wait_cyc(4);
  endtask

  task automatic host_edge();
    joy_clk = 1'b1;
    wait_cyc(4);
    joy_clk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic push_frame();
    logic [31:0] f;
    f = {~joystick2, ~joystick1};
    for (int i = 0; i < 32; i++) exp_q.push_back(f[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    wait_cyc(3);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (joy_data !== 1'b1) begin
      errors++; $display("FAIL reset_data: joy_data=%b expected 1", joy_data);
    end
    checks++;
    if (link_active !== 1'b0) begin
      errors++; $display("FAIL reset_link: link_active=%b expected 0", link_active);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_frame();
    joystick1 = 16'h0011;
    joystick2 = 16'h8000;
    exp_q.delete();
    host_load();
    push_frame();
    checks++;
    if (link_active !== 1'b1) begin
      errors++; $display("FAIL frame_link: link_active=%b expected 1", link_active);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == 3) begin
        joystick1 = 16'hFFFF;
        joystick2 = 16'h0000;
      end
      exp_bit = exp_q.pop_front();
      checks++;
      if (joy_data !== exp_bit) begin
        errors++; $display("FAIL frame_bit%0d: joy_data=%b expected %b", i, joy_data, exp_bit);
      end
      host_edge();
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL frame_overrun: overrun=%b expected 0", overrun);
    end
    checks++;
    if (joy_data !== 1'b1) begin
      errors++; $display("FAIL frame_fill: joy_data=%b expected 1", joy_data);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 3; i++) begin
      host_edge();
      checks++;
      if (joy_data !== 1'b1) begin
        errors++; $display("FAIL overrun_data%0d: joy_data=%b expected 1", i, joy_data);
      end
      checks++;
      if (overrun !== 1'b1) begin
        errors++; $display("FAIL overrun_flag%0d: overrun=%b expected 1", i, overrun);
      end
    end
    wait_cyc(10);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_held: overrun=%b expected 1", overrun);
    end
  endtask

  task automatic test_midframe_load();
    pulse_reset();
    joystick1 = 16'h1234;
    joystick2 = 16'h0F0F;
    exp_q.delete();
    host_load();
    push_frame();
    for (int i = 0; i < 10; i++) begin
      exp_bit = exp_q.pop_front();
      checks++;
      if (joy_data !== exp_bit) begin
        errors++; $display("FAIL mid_pre_bit%0d: joy_data=%b expected %b", i, joy_data, exp_bit);
      end
      host_edge();
    end
    exp_q.delete();
    joystick1 = 16'h0001;
    host_load();
    push_frame();
    for (int i = 0; i < 32; i++) begin
      exp_bit = exp_q.pop_front();
      checks++;
      if (joy_data !== exp_bit) begin
        errors++; $display("FAIL mid_post_bit%0d: joy_data=%b expected %b", i, joy_data, exp_bit);
      end
      host_edge();
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL mid_overrun: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_coincident();
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;
    exp_q.delete();
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    wait_cyc(4);
    joy_load = 1'b1;
    wait_cyc(4);
    joy_clk  = 1'b0;
    wait_cyc(4);
    push_frame();
    for (int i = 0; i < 32; i++) begin
      exp_bit = exp_q.pop_front();
      checks++;
      if (joy_data !== exp_bit) begin
        errors++; $display("FAIL coinc_bit%0d: joy_data=%b expected %b", i, joy_data, exp_bit);
      end
      host_edge();
    end
  endtask

  task automatic test_reset_midframe();
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    host_load();
    for (int i = 0; i < 5; i++) host_edge();
    pulse_reset();
    @(negedge clk);
    checks++;
    if (joy_data !== 1'b1) begin
      errors++; $display("FAIL rstmid_data: joy_data=%b expected 1", joy_data);
    end
    checks++;
    if (link_active !== 1'b0) begin
      errors++; $display("FAIL rstmid_link: link_active=%b expected 0", link_active);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_overrun: overrun=%b expected 0", overrun);
    end
    joystick1 = 16'hA5C3;
    joystick2 = 16'h3C5A;
    exp_q.delete();
    host_load();
    push_frame();
    for (int i = 0; i < 32; i++) begin
      exp_bit = exp_q.pop_front();
      checks++;
      if (joy_data !== exp_bit) begin
        errors++; $display("FAIL rstmid_bit%0d: joy_data=%b expected %b", i, joy_data, exp_bit);
      end
      host_edge();
    end
  endtask

  task automatic test_link_hold();
    bit exp_late;
`ifdef DB15_TX_TIMEOUT_EN
    exp_late = 1'b0;
`else
    exp_late = 1'b1;
`endif
    host_load();
    wait_cyc(85);
    checks++;
    if (link_active !== 1'b1) begin
      errors++; $display("FAIL link_early: link_active=%b expected 1", link_active);
    end
    wait_cyc(25);
    checks++;
    if (link_active !== exp_late) begin
      errors++; $display("FAIL link_late: link_active=%b expected %b", link_active, exp_late);
    end
    host_load();
    checks++;
    if (link_active !== 1'b1) begin
      errors++; $display("FAIL link_reload: link_active=%b expected 1", link_active);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_midframe_load();
    test_coincident();
    test_reset_midframe();
    test_link_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
